// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Optional parity bit is enabled by defining SERIAL_PATTERN_TX_PARITY_EN.
package serial_tx_pkg;

    localparam int unsigned TX_STATE_W = 2;

    // Reference sequence recognised by the downstream detector
    localparam logic [3:0] PATTERN_1101 = 4'b1101;

    typedef enum logic [TX_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Control/stream bundle between a pattern source user and the transmitter.
interface serial_pattern_tx_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
);
    import serial_tx_pkg::*;

    logic                  start;
    logic [WIDTH-1:0]      pattern;
    logic [LEN_W-1:0]      len;
    logic                  tx_bit;
    logic                  tx_valid;
    logic                  busy;
    logic                  done;
    logic [TX_STATE_W-1:0] state;

    // Requester side: issues start/pattern/len, observes the stream
    modport master (
        output start, pattern, len,
        input  tx_bit, tx_valid, busy, done, state
    );

    // Transmitter side
    modport slave (
        input  start, pattern, len,
        output tx_bit, tx_valid, busy, done, state
    );

endinterface

// File: rtl/serial_tx_shreg.sv
// WIDTH-bit load / shift-left register exposing its top two bits.
module serial_tx_shreg
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb,
    output logic             next_msb
);

    logic [WIDTH-1:0] q;

    // Load has priority; shifting fills with zeros from the LSB
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb      = q[WIDTH-1];
    assign next_msb = q[WIDTH-2];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: MSB-first shift-out of a latched pattern
// with valid/busy/done status. Define SERIAL_PATTERN_TX_PARITY_EN to
// append an even-parity bit after the data bits.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_pattern_tx_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(WIDTH + 1);

    tx_state_t        state_q;
    logic [LEN_W-1:0] count_q;
    logic             tx_bit_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             shreg_load;
    logic             shreg_shift;
    logic             shreg_msb;
    logic             shreg_next_msb;
    logic [LEN_W-1:0] len_eff;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic             parity_q;
`endif

    // Clamp requested length to the register width
    always_comb begin
        len_eff = bus.len;
        if (bus.len > LEN_W'(WIDTH)) begin
            len_eff = LEN_W'(WIDTH);
        end
    end

    // Shift register is loaded on an accepted start, advanced once per data bit
    assign shreg_load  = (state_q == ST_IDLE) && bus.start;
    assign shreg_shift = (state_q == ST_SHIFT);

    serial_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (shreg_load),
        .shift    (shreg_shift),
        .din      (bus.pattern),
        .msb      (shreg_msb),
        .next_msb (shreg_next_msb)
    );

    // Transfer FSM; outputs are registered so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        count_q <= len_eff;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        parity_q <= 1'b0;
`endif
                        if (len_eff == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // First bit comes straight from the pattern being loaded
                            state_q    <= ST_SHIFT;
                            tx_bit_q   <= bus.pattern[WIDTH-1];
                            tx_valid_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end

                ST_SHIFT: begin
                    // tx_bit_q mirrors shreg_msb during this state
                    count_q <= count_q - LEN_W'(1);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    parity_q <= parity_q ^ shreg_msb;
`endif
                    if (count_q == LEN_W'(1)) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        state_q  <= ST_PARITY;
                        tx_bit_q <= parity_q ^ shreg_msb;
`else
                        state_q    <= ST_DONE;
                        tx_bit_q   <= 1'b0;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
`endif
                    end else begin
                        tx_bit_q <= shreg_next_msb;
                    end
                end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
                ST_PARITY: begin
                    state_q    <= ST_DONE;
                    tx_bit_q   <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                end
`endif

                ST_DONE: begin
                    // start is deliberately not looked at here
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    tx_bit_q   <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_bit   = tx_bit_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;

endmodule
